load_3_sched: RTL and testbench
===============================

LOAD_3_SCHED -- requirements
Module: load_3_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one load_3 datapath; legal values 2..8.
REQ-002 SHALL have parameter LAT, default 2: datapath latency in cycles from operands to valid dp_result; legal values 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester request level.
REQ-006 SHALL have ports s0_in, s1_in and s2_in, input, 8*NREQ bits each: packed operands; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port gnt, output, NREQ bits: one-hot, one-cycle grant pulse.
REQ-008 SHALL have ports dp_s0, dp_s1 and dp_s2, output, 8 bits each: registered operands driven to the shared datapath.
REQ-009 SHALL have port dp_result, input, 64 bits: datapath result.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-012 SHALL have port rsp_id, output, clog2(NREQ) bits: index of the requester that owns the response.
REQ-013 SHALL have port rsp_data, output, 64 bits: captured result.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement an FSM with exactly three states, IDLE, WAIT and RESP, plus a cycle counter cnt and a last-granted register last.
REQ-016 In IDLE with req==0, SHALL remain in IDLE with all outputs holding.
REQ-017 In IDLE with req!=0, SHALL select winner w = first set bit of req searching from (last+1) mod NREQ upward with wrap-around.
REQ-018 On that selecting edge, SHALL load gnt<=onehot(w), dp_s0/1/2<=operands of w, last<=w, cnt<=0 and state<=WAIT.
REQ-019 SHALL hold gnt high for exactly one cycle and clear it on the next edge.
REQ-020 SHALL hold dp_s0/1/2 stable from the selecting edge until the next grant.
REQ-021 In WAIT, SHALL increment cnt each edge; at the edge where cnt==LAT-1, SHALL load rsp_data<=dp_result, rsp_id<=last, rsp_valid<=1 and state<=RESP.
REQ-022 Consequence of REQ-021: dp_result SHALL be sampled exactly LAT edges after the selecting edge.
REQ-023 In RESP, SHALL hold rsp_valid, rsp_data and rsp_id stable while rsp_ready is low.
REQ-024 In RESP with rsp_ready high at an edge, SHALL clear rsp_valid and return to IDLE; rsp_data and rsp_id SHALL keep their last values.
REQ-025 SHALL NOT grant in the same cycle a response is accepted; the earliest next grant is the edge after return to IDLE (throughput 1 request per LAT+2 cycles with rsp_ready=1).
REQ-026 Requesters drop req after gnt; a req still high in IDLE SHALL be treated as a new request.
REQ-027 SHALL ignore req changes during WAIT and RESP.
REQ-028 SHALL never assert more than one gnt bit; gnt SHALL be 0 outside the selecting cycle.
REQ-029 SHALL drive busy combinationally from the state register.

Reset
REQ-030 While rst is low, SHALL immediately force state=IDLE, gnt=0, dp_s0/1/2=0, rsp_valid=0, rsp_id=0, rsp_data=0, cnt=0, last=NREQ-1 and busy=0, independent of clk.
REQ-031 Reset asserted mid-WAIT or mid-RESP SHALL abandon the transaction with no response issued.
REQ-032 After reset release, the first grant SHALL go to the lowest-indexed active requester.

Verification
Bench setup: datapath stub returns {40'h0, dp_s0, dp_s1, dp_s2} delayed by LAT cycles; defaults NREQ=4, LAT=2.
REQ-033 Single request: req=4'b0100, ch2 operands F0/2E/27, rsp_ready=1 -> gnt=0100 for 1 cycle; dp_s0/1/2=F0/2E/27; rsp_valid 2 edges later with rsp_id=2 and rsp_data=64'h0000_0000_00F0_2E27.
REQ-034 All four req held high with rsp_ready=1 -> grant order 0,1,2,3,0, each grant LAT+2=4 cycles apart.
REQ-035 Backpressure: rsp_ready low for 5 cycles while req=0011 -> rsp_valid, rsp_id and rsp_data stable; no gnt; next gnt (ch1) the edge after rsp_ready is sampled high plus one.
REQ-036 Reset mid-WAIT: rst low 1 cycle after gnt -> all outputs 0 asynchronously; no rsp_valid; after release with req=1000 the first gnt is 1000.
REQ-037 LAT=1 build: single req on ch0 -> rsp_valid one edge after the grant edge with correct data.
REQ-038 Wrap-around: last=3 and req=1001 -> gnt=0001; then gnt=1000.

Source files
------------

// File: rtl/load_3_sched.sv
// Round-robin scheduler sharing one load_3 datapath among NREQ requesters.
// Grant LAT+2 cycles apart at best; response held until rsp_ready.
module load_3_sched #(
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [8*NREQ-1:0]        s0_in,
   input  logic [8*NREQ-1:0]        s1_in,
   input  logic [8*NREQ-1:0]        s2_in,
   output logic [NREQ-1:0]          gnt,
   output logic [7:0]               dp_s0,
   output logic [7:0]               dp_s1,
   output logic [7:0]               dp_s2,
   input  logic [63:0]              dp_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [63:0]              rsp_data,
   output logic                     busy
);
   localparam int IDW = $clog2(NREQ);
   localparam logic [3:0] CNT_END = 4'(LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state, nxt;
   logic [3:0]     cnt;
   logic [IDW-1:0] last;
   logic [IDW-1:0] win;
   logic [IDW-1:0] cand;
   logic           found;

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      win   = last;
      cand  = last;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (found) nxt = WAIT;
         WAIT:    if (cnt == CNT_END) nxt = RESP;
         RESP:    if (rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt       <= '0;
         dp_s0     <= '0;
         dp_s1     <= '0;
         dp_s2     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         cnt       <= '0;
         last      <= IDW'(NREQ - 1);
      end else begin
         gnt <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  gnt   <= NREQ'(1) << win;
                  dp_s0 <= s0_in[{win, 3'b000} +: 8];
                  dp_s1 <= s1_in[{win, 3'b000} +: 8];
                  dp_s2 <= s2_in[{win, 3'b000} +: 8];
                  last  <= win;
                  cnt   <= '0;
               end
            end
            WAIT: begin
               cnt <= cnt + 4'd1;
               // Operands were launched LAT edges ago, so dp_result is valid now.
               if (cnt == CNT_END) begin
                  rsp_data  <= dp_result;
                  rsp_id    <= last;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_load_3_sched.sv
// Randomized and directed bench for load_3_sched with a transaction-level round-robin model.
module tb_load_3_sched;
   logic        clk;
   logic        rst;
   // Instance A: NREQ=4, LAT=2
   logic [3:0]  req;
   logic [31:0] s0, s1, s2;
   logic [3:0]  gnt;
   logic [7:0]  dp_s0, dp_s1, dp_s2;
   logic [63:0] dp_result;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic [63:0] rsp_data;
   logic        busy;
   // Instance B: NREQ=4, LAT=1
   logic [3:0]  req_b;
   logic [31:0] s0_b, s1_b, s2_b;
   logic [3:0]  gnt_b;
   logic [7:0]  dp_s0_b, dp_s1_b, dp_s2_b;
   logic [63:0] dp_result_b;
   logic        rsp_valid_b, rsp_ready_b;
   logic [1:0]  rsp_id_b;
   logic [63:0] rsp_data_b;
   logic        busy_b;

   int checks = 0;
   int errors = 0;
   int mlast;
   logic [7:0]  ops [4][3];
   logic [63:0] dly0;

   load_3_sched #(.NREQ(4), .LAT(2)) u_a (
      .clk(clk), .rst(rst), .req(req), .s0_in(s0), .s1_in(s1), .s2_in(s2),
      .gnt(gnt), .dp_s0(dp_s0), .dp_s1(dp_s1), .dp_s2(dp_s2), .dp_result(dp_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy));

   load_3_sched #(.NREQ(4), .LAT(1)) u_b (
      .clk(clk), .rst(rst), .req(req_b), .s0_in(s0_b), .s1_in(s1_b), .s2_in(s2_b),
      .gnt(gnt_b), .dp_s0(dp_s0_b), .dp_s1(dp_s1_b), .dp_s2(dp_s2_b), .dp_result(dp_result_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
      .rsp_data(rsp_data_b), .busy(busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stubs: LAT=2 needs one register stage, LAT=1 is combinational.
   always @(posedge clk) dly0 <= {40'h0, dp_s0, dp_s1, dp_s2};
   assign dp_result   = dly0;
   assign dp_result_b = {40'h0, dp_s0_b, dp_s1_b, dp_s2_b};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input int lst, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (lst + k) % 4;
         if (r[c[1:0]]) return c;
      end
      return -1;
   endfunction

   function automatic logic [63:0] exp_data(input int ch);
      return {40'h0, ops[ch][0], ops[ch][1], ops[ch][2]};
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < 4; i++) begin
         s0[8*i +: 8] = ops[i][0];
         s1[8*i +: 8] = ops[i][1];
         s2[8*i +: 8] = ops[i][2];
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      mlast = 3;
   endtask

   task automatic test_reset();
      #2;
      checks++; if ({gnt, dp_s0, dp_s1, dp_s2} !== 28'h0) begin errors++; $display("FAIL reset_gnt_dp got %h exp 0", {gnt, dp_s0, dp_s1, dp_s2}); end
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== 67'h0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_id, rsp_data}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      req = 4'b1111;
      step(); step();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_no_gnt got %b exp 0000", gnt); end
      req = 4'b0000;
      rst = 1'b1;
      mlast = 3;
   endtask

   task automatic test_single();
      ops[2][0] = 8'hF0; ops[2][1] = 8'h2E; ops[2][2] = 8'h27;
      drive_ops();
      req = 4'b0100; rsp_ready = 1'b1;
      step();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
      checks++; if ({dp_s0, dp_s1, dp_s2} !== 24'hF02E27) begin errors++; $display("FAIL single_dp got %h exp F02E27", {dp_s0, dp_s1, dp_s2}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
      mlast = 2;
      req = 4'b0000;
      step();
      checks++; if ({gnt, rsp_valid} !== 5'b0) begin errors++; $display("FAIL single_gnt_pulse got %b exp 00000", {gnt, rsp_valid}); end
      step();
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 64'h0000_0000_00F0_2E27}) begin errors++; $display("FAIL single_rsp got %b/%0d/%h exp 1/2/F02E27", rsp_valid, rsp_id, rsp_data); end
      step();
      checks++; if ({rsp_valid, busy, rsp_id, rsp_data} !== {1'b0, 1'b0, 2'd2, 64'h0000_0000_00F0_2E27}) begin errors++; $display("FAIL single_accept got %b/%b/%0d/%h", rsp_valid, busy, rsp_id, rsp_data); end
   endtask

   task automatic test_round_robin();
      int q[$];
      int ngr, lastcyc, cyc, w;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         ops[i][0] = 8'h10 + 8'(i); ops[i][1] = 8'h20 + 8'(i); ops[i][2] = 8'h30 + 8'(i);
      end
      drive_ops();
      req = 4'b1111; rsp_ready = 1'b1;
      ngr = 0; lastcyc = 0; cyc = 0;
      while (ngr < 5 && cyc < 40) begin
         step(); cyc++;
         if (gnt !== 4'b0000) begin
            w = pick(mlast, req);
            checks++; if (gnt !== (4'b0001 << w)) begin errors++; $display("FAIL rr_order got %b exp ch%0d", gnt, w); end
            if (ngr > 0) begin
               checks++; if (cyc - lastcyc != 4) begin errors++; $display("FAIL rr_gap got %0d exp 4", cyc - lastcyc); end
            end
            mlast = w; lastcyc = cyc; ngr++;
            q.push_back(w);
         end
         if (rsp_valid) begin
            checks++; if (q.size() == 0 || rsp_id !== 2'(q[0]) || rsp_data !== exp_data(q[0])) begin errors++; $display("FAIL rr_rsp got %0d/%h", rsp_id, rsp_data); end
            if (q.size() > 0) void'(q.pop_front());
         end
      end
      checks++; if (ngr != 5) begin errors++; $display("FAIL rr_count got %0d exp 5", ngr); end
      req = 4'b0000;
      for (int i = 0; i < 10 && (busy || rsp_valid); i++) begin
         step();
         if (rsp_valid) begin
            checks++; if (q.size() == 0 || rsp_id !== 2'(q[0]) || rsp_data !== exp_data(q[0])) begin errors++; $display("FAIL rr_tail_rsp got %0d/%h", rsp_id, rsp_data); end
            if (q.size() > 0) void'(q.pop_front());
         end
      end
      checks++; if (busy !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rr_drain got busy=%b pending=%0d exp 0/0", busy, q.size()); end
   endtask

   task automatic test_backpressure();
      logic [63:0] d0;
      apply_reset();
      ops[0][0] = 8'hA1; ops[0][1] = 8'hB2; ops[0][2] = 8'hC3;
      ops[1][0] = 8'h44; ops[1][1] = 8'h55; ops[1][2] = 8'h66;
      drive_ops();
      d0 = exp_data(0);
      req = 4'b0011; rsp_ready = 1'b0;
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt0 got %b exp 0001", gnt); end
      step(); step();
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, d0}) begin errors++; $display("FAIL bp_rsp got %b/%0d/%h exp 1/0/%h", rsp_valid, rsp_id, rsp_data, d0); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if ({rsp_valid, rsp_id, rsp_data, gnt} !== {1'b1, 2'd0, d0, 4'b0}) begin errors++; $display("FAIL bp_hold cyc%0d got %b/%0d/%h/%b", i, rsp_valid, rsp_id, rsp_data, gnt); end
      end
      rsp_ready = 1'b1;
      step();
      checks++; if ({rsp_valid, gnt, rsp_id, rsp_data} !== {1'b0, 4'b0, 2'd0, d0}) begin errors++; $display("FAIL bp_accept got %b/%b/%0d/%h", rsp_valid, gnt, rsp_id, rsp_data); end
      step();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_next_gnt got %b exp 0010", gnt); end
      mlast = 1;
      req = 4'b0000;
      for (int i = 0; i < 10 && (busy || rsp_valid); i++) step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain got busy=%b exp 0", busy); end
   endtask

   task automatic test_reset_mid_wait();
      int nrsp;
      ops[2][0] = 8'h12; ops[2][1] = 8'h34; ops[2][2] = 8'h56;
      ops[3][0] = 8'h9A; ops[3][1] = 8'hBC; ops[3][2] = 8'hDE;
      drive_ops();
      req = 4'b0100; rsp_ready = 1'b1;
      step();
      checks++; if (gnt !== (4'b0001 << pick(mlast, 4'b0100))) begin errors++; $display("FAIL rmw_gnt got %b exp 0100", gnt); end
      req = 4'b0000;
      step();
      #2 rst = 1'b0;
      #1;
      checks++; if ({gnt, dp_s0, dp_s1, dp_s2, rsp_valid, rsp_id, rsp_data, busy} !== 96'h0) begin errors++; $display("FAIL rmw_async_clear got %h exp 0", {gnt, dp_s0, dp_s1, dp_s2, rsp_valid, rsp_id, rsp_data, busy}); end
      step();
      rst = 1'b1;
      mlast = 3;
      nrsp = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rsp_valid) nrsp++;
      end
      checks++; if (nrsp != 0 || busy !== 1'b0) begin errors++; $display("FAIL rmw_no_rsp got rsp=%0d busy=%b exp 0/0", nrsp, busy); end
      req = 4'b1000;
      step();
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rmw_first_gnt got %b exp 1000", gnt); end
      mlast = 3;
      req = 4'b0000;
      nrsp = 0;
      for (int i = 0; i < 10 && (busy || rsp_valid); i++) begin
         step();
         if (rsp_valid) begin
            nrsp++;
            checks++; if (rsp_id !== 2'd3 || rsp_data !== exp_data(3)) begin errors++; $display("FAIL rmw_rsp got %0d/%h exp 3/%h", rsp_id, rsp_data, exp_data(3)); end
         end
      end
      checks++; if (nrsp != 1) begin errors++; $display("FAIL rmw_rsp_count got %0d exp 1", nrsp); end
   endtask

   task automatic test_wrap();
      int cyc;
      logic seen;
      req = 4'b1001; rsp_ready = 1'b1;
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b exp 0001", gnt); end
      mlast = 0;
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 12) begin
         step(); cyc++;
         if (gnt !== 4'b0000) seen = 1'b1;
      end
      checks++; if (gnt !== 4'b1000 || cyc != 4) begin errors++; $display("FAIL wrap_second got %b after %0d exp 1000 after 4", gnt, cyc); end
      mlast = 3;
      req = 4'b0000;
      for (int i = 0; i < 10 && (busy || rsp_valid); i++) step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_drain got busy=%b exp 0", busy); end
   endtask

   task automatic test_lat1();
      s0_b = 32'h0000_005A; s1_b = 32'h0000_006B; s2_b = 32'h0000_007C;
      req_b = 4'b0001; rsp_ready_b = 1'b1;
      step();
      checks++; if (gnt_b !== 4'b0001) begin errors++; $display("FAIL lat1_gnt got %b exp 0001", gnt_b); end
      req_b = 4'b0000;
      step();
      checks++; if ({rsp_valid_b, rsp_id_b, rsp_data_b} !== {1'b1, 2'd0, 64'h5A6B7C}) begin errors++; $display("FAIL lat1_rsp got %b/%0d/%h exp 1/0/5A6B7C", rsp_valid_b, rsp_id_b, rsp_data_b); end
      step();
      checks++; if ({rsp_valid_b, busy_b} !== 2'b00) begin errors++; $display("FAIL lat1_done got %b exp 00", {rsp_valid_b, busy_b}); end
   endtask

   task automatic test_random();
      int w, stall;
      logic [3:0]  r;
      logic [63:0] ed;
      rsp_ready = 1'b0;
      for (int t = 0; t < 40; t++) begin
         r = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) ops[i][j] = 8'($urandom);
         drive_ops();
         req = r;
         w = pick(mlast, r);
         ed = exp_data(w);
         step();
         checks++; if (gnt !== (4'b0001 << w) || {40'h0, dp_s0, dp_s1, dp_s2} !== ed) begin errors++; $display("FAIL rnd_gnt t%0d got %b/%h exp ch%0d/%h", t, gnt, {dp_s0, dp_s1, dp_s2}, w, ed); end
         mlast = w;
         // Requests and operands moving during the transaction must have no effect.
         req = 4'($urandom);
         s0 = $urandom; s1 = $urandom; s2 = $urandom;
         step();
         checks++; if ({gnt, rsp_valid} !== 5'b0) begin errors++; $display("FAIL rnd_wait t%0d got %b exp 00000", t, {gnt, rsp_valid}); end
         req = 4'b0000;
         step();
         checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(w), ed}) begin errors++; $display("FAIL rnd_rsp t%0d got %b/%0d/%h exp 1/%0d/%h", t, rsp_valid, rsp_id, rsp_data, w, ed); end
         stall = $urandom_range(0, 3);
         for (int i = 0; i < stall; i++) begin
            step();
            checks++; if ({rsp_valid, rsp_id, rsp_data, gnt} !== {1'b1, 2'(w), ed, 4'b0}) begin errors++; $display("FAIL rnd_hold t%0d got %b/%0d/%h/%b", t, rsp_valid, rsp_id, rsp_data, gnt); end
         end
         rsp_ready = 1'b1;
         step();
         checks++; if ({rsp_valid, busy, gnt} !== 6'b0) begin errors++; $display("FAIL rnd_accept t%0d got %b exp 000000", t, {rsp_valid, busy, gnt}); end
         rsp_ready = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b0;
      req = '0; s0 = '0; s1 = '0; s2 = '0; rsp_ready = 1'b0;
      req_b = '0; s0_b = '0; s1_b = '0; s2_b = '0; rsp_ready_b = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++) ops[i][j] = 8'h0;
      mlast = 3;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid_wait();
      test_wrap();
      test_lat1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
